// File: rtl/paicore_rx_pkg.sv
// Shared definitions for the 2-channel PAICORE receive path: link/AXIS widths,
// the per-channel handshake state encoding and the frame-length helper.
package paicore_rx_pkg;

    localparam int HALF_WD = 32;
    localparam int DATA_WD = 2 * HALF_WD;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LO = 1'b1
    } ch_state_t;

    // A programmed length of zero still produces one-word frames.
    function automatic logic [31:0] len_eff(input logic [31:0] recv_len);
        return (recv_len == 32'd0) ? 32'd1 : recv_len;
    endfunction

endpackage

// File: rtl/paicore_hs_rx_chan.sv
// One PAICORE output link: request synchroniser, 4-phase handshake FSM,
// half-word packer and a small word buffer exposed as a valid/ready port.
module paicore_hs_rx_chan #(
    parameter int HALF_WD     = paicore_rx_pkg::HALF_WD,
    parameter int SYNC_STAGES = 2,
    parameter int CH_DEPTH    = 2
) (
    input  logic                   s_axis_aclk,
    input  logic                   rst_n,
    input  logic                   rx_enable,
    input  logic                   request,
    input  logic [HALF_WD-1:0]     din,
    output logic                   acknowledge,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [2*HALF_WD-1:0]   word_data
);
    import paicore_rx_pkg::*;

    localparam int              PTR_WD  = (CH_DEPTH > 1) ? $clog2(CH_DEPTH) : 1;
    localparam logic [PTR_WD:0] DEPTH_C = (PTR_WD + 1)'(CH_DEPTH);
    localparam logic [PTR_WD:0] ONE_C   = (PTR_WD + 1)'(1);

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    ch_state_t              state, state_nxt;
    logic                   capture, release_hs;
    logic                   half;
    logic [HALF_WD-1:0]     hi_reg;
    logic [2*HALF_WD-1:0]   mem [CH_DEPTH];
    logic [PTR_WD-1:0]      wr_idx, rd_idx;
    logic [PTR_WD:0]        count;
    logic                   full, push, pop;

    function automatic logic [PTR_WD-1:0] next_idx(input logic [PTR_WD-1:0] i);
        return (i == PTR_WD'(CH_DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    assign req_s = req_sync[SYNC_STAGES-1];
    assign full  = (count == DEPTH_C);
    assign push  = capture && half;
    assign pop   = word_valid && word_ready;

    // Request synchroniser: the link drives request from its own clock domain.
    // NOTE: every clocked block uses non-blocking assignments so all flops update together.
    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) req_sync <= '0;
        else        req_sync <= (req_sync << 1) | SYNC_STAGES'(request);
    end

    // Handshake state register.
    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: refuse a second half while the buffer cannot take the finished word.
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_s && rx_enable && !(half && full)) state_nxt = WAIT_LO;
            WAIT_LO: if (!req_s)                               state_nxt = IDLE;
            default:                                           state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state and its transitions.
    always_comb begin
        acknowledge = (state == WAIT_LO);
        capture     = (state == IDLE)    && (state_nxt == WAIT_LO);
        release_hs  = (state == WAIT_LO) && (state_nxt == IDLE);
    end

    // Packer and buffer bookkeeping: upper half first, lower half completes the word.
    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            half   <= 1'b0;
            hi_reg <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (capture && !half) hi_reg <= din;
            if (release_hs)       half   <= ~half;
            if (push)             wr_idx <= next_idx(wr_idx);
            if (pop)              rd_idx <= next_idx(rd_idx);
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: ;
            endcase
        end
    end

    // Word storage, written in the same edge the lower half is captured.
    // NOTE: storage is deliberately not reset; count gates every read.
    always_ff @(posedge s_axis_aclk) begin
        if (push) mem[wr_idx] <= {hi_reg, din};
    end

    assign word_valid = (count != '0);
    assign word_data  = mem[rd_idx];

endmodule

// File: rtl/paicore_recv_2c.sv
// Receive side of the 2-channel PAICORE path: two link receivers merged
// round-robin into one AXI-Stream master with frame tlast and beat counting.
module paicore_recv_2c #(
    parameter int DATA_WD     = paicore_rx_pkg::DATA_WD,
    parameter int HALF_WD     = paicore_rx_pkg::HALF_WD,
    parameter int SYNC_STAGES = 2,
    parameter int CH_DEPTH    = 2
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_aresetn,
    input  logic               rx_enable,
    input  logic [31:0]        recv_len,
    output logic [31:0]        data_cnt,
    input  logic               request_C0,
    input  logic               request_C1,
    input  logic [HALF_WD-1:0] din_C0,
    input  logic [HALF_WD-1:0] din_C1,
    output logic               acknowledge_C0,
    output logic               acknowledge_C1,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [DATA_WD-1:0] m_axis_tdata,
    output logic               m_axis_tlast,
    output logic               o_rx_done
);
    import paicore_rx_pkg::*;

    logic [1:0]         rst_sync;
    logic               rst_n;
    logic               c0_valid, c1_valid, c0_ready, c1_ready;
    logic [DATA_WD-1:0] c0_data, c1_data, word_sel;
    logic               rr, sel, any_valid, grant, load_en, hs, next_last;
    logic [31:0]        frame_cnt, cnt_next, len_hold, len_now, len_load;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) rst_sync <= 2'b00;
        else                 rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    paicore_hs_rx_chan #(
        .HALF_WD(HALF_WD), .SYNC_STAGES(SYNC_STAGES), .CH_DEPTH(CH_DEPTH)
    ) u_chan0 (
        .s_axis_aclk(s_axis_aclk), .rst_n(rst_n), .rx_enable(rx_enable),
        .request(request_C0), .din(din_C0), .acknowledge(acknowledge_C0),
        .word_valid(c0_valid), .word_ready(c0_ready), .word_data(c0_data)
    );

    paicore_hs_rx_chan #(
        .HALF_WD(HALF_WD), .SYNC_STAGES(SYNC_STAGES), .CH_DEPTH(CH_DEPTH)
    ) u_chan1 (
        .s_axis_aclk(s_axis_aclk), .rst_n(rst_n), .rx_enable(rx_enable),
        .request(request_C1), .din(din_C1), .acknowledge(acknowledge_C1),
        .word_valid(c1_valid), .word_ready(c1_ready), .word_data(c1_data)
    );

    // Merge selection and the frame position the next loaded word will occupy.
    always_comb begin
        load_en   = !m_axis_tvalid || m_axis_tready;
        hs        = m_axis_tvalid && m_axis_tready;
        any_valid = c0_valid || c1_valid;
        sel       = (c0_valid && c1_valid) ? rr : c1_valid;
        grant     = load_en && any_valid;
        c0_ready  = grant && !sel;
        c1_ready  = grant && sel;
        word_sel  = sel ? c1_data : c0_data;
        cnt_next  = hs ? (m_axis_tlast ? 32'd0 : frame_cnt + 32'd1) : frame_cnt;
        len_now   = (frame_cnt == 32'd0) ? len_eff(recv_len) : len_hold;
        len_load  = (cnt_next == 32'd0) ? len_eff(recv_len) : len_now;
        next_last = (cnt_next == len_load - 32'd1);
    end

    // Output register: reload only when empty or when its word is taken.
    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_en) begin
            m_axis_tvalid <= any_valid;
            m_axis_tlast  <= any_valid && next_last;
            if (any_valid) m_axis_tdata <= word_sel;
        end
    end

    // Round-robin pointer points at the channel that did not win last.
    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n)     rr <= 1'b0;
        else if (grant) rr <= ~sel;
    end

    // Frame position, frozen frame length, beat count and done pulse.
    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            len_hold  <= 32'd1;
            data_cnt  <= '0;
            o_rx_done <= 1'b0;
        end else begin
            frame_cnt <= cnt_next;
            len_hold  <= len_now;
            data_cnt  <= data_cnt + 32'(hs);
            o_rx_done <= hs && m_axis_tlast;
        end
    end

endmodule

// File: tb/tb_paicore_recv_2c.sv
// Directed bench for paicore_recv_2c: link drivers, a frame/beat scoreboard
// checked every cycle, and literal expectations for each scenario.
`timescale 1ns/1ps
module tb_paicore_recv_2c;

    logic        s_axis_aclk = 1'b0;
    logic        s_axis_aresetn;
    logic        rx_enable;
    logic [31:0] recv_len;
    logic [31:0] data_cnt;
    logic        request_C0, request_C1;
    logic [31:0] din_C0, din_C1;
    logic        acknowledge_C0, acknowledge_C1;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, o_rx_done;
    logic [63:0] m_axis_tdata;

    always #5 s_axis_aclk = ~s_axis_aclk;

    paicore_recv_2c dut (
        .s_axis_aclk(s_axis_aclk), .s_axis_aresetn(s_axis_aresetn),
        .rx_enable(rx_enable), .recv_len(recv_len), .data_cnt(data_cnt),
        .request_C0(request_C0), .request_C1(request_C1),
        .din_C0(din_C0), .din_C1(din_C1),
        .acknowledge_C0(acknowledge_C0), .acknowledge_C1(acknowledge_C1),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .o_rx_done(o_rx_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state
    logic [63:0] exp_q[$];
    logic [63:0] log_data[$];
    logic        log_last[$];
    logic [31:0] cnt_model = '0;
    logic [31:0] pos_model = '0;
    logic [31:0] len_model = 32'd1;
    logic        done_next = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          done_count = 0;
    logic        bp_done;

    function automatic logic [63:0] w0(input int k);
        return {32'hC0A0_0000 + 32'(k), 32'hC0B0_0000 + 32'(k)};
    endfunction
    function automatic logic [63:0] w1(input int k);
        return {32'hC1A0_0000 + 32'(k), 32'hC1B0_0000 + 32'(k)};
    endfunction

    // Every-cycle comparison against the frame/beat model.
    initial begin
        logic        exp_last;
        logic [63:0] exp_data;
        forever begin
            @(negedge s_axis_aclk);
            if (!s_axis_aresetn) begin
                check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
                check("rst_tlast", 64'(m_axis_tlast), 64'd0);
                check("rst_tdata", m_axis_tdata, 64'd0);
                check("rst_data_cnt", 64'(data_cnt), 64'd0);
                check("rst_done", 64'(o_rx_done), 64'd0);
                check("rst_ack_C0", 64'(acknowledge_C0), 64'd0);
                check("rst_ack_C1", 64'(acknowledge_C1), 64'd0);
                cnt_model  = '0;
                pos_model  = '0;
                done_next  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("data_cnt", 64'(data_cnt), 64'(cnt_model));
                check("o_rx_done", 64'(o_rx_done), 64'(done_next));
                if (o_rx_done) done_count++;
                if (prev_stall) begin
                    check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                    check("hold_tdata", m_axis_tdata, prev_data);
                    check("hold_tlast", 64'(m_axis_tlast), 64'(prev_last));
                end
                done_next = 1'b0;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (pos_model == 32'd0) len_model = (recv_len == 32'd0) ? 32'd1 : recv_len;
                    exp_last = (pos_model == len_model - 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_axis_tdata);
                    end else begin
                        exp_data = exp_q.pop_front();
                        check("tdata", m_axis_tdata, exp_data);
                    end
                    check("tlast", 64'(m_axis_tlast), 64'(exp_last));
                    log_data.push_back(m_axis_tdata);
                    log_last.push_back(m_axis_tlast);
                    cnt_model = cnt_model + 32'd1;
                    pos_model = exp_last ? 32'd0 : pos_model + 32'd1;
                    done_next = exp_last;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge s_axis_aclk);
        #1;
    endtask

    task automatic wait_ack(input int ch, input logic val, input string what);
        int n = 0;
        while (((ch == 0) ? acknowledge_C0 : acknowledge_C1) !== val && n < 400) begin
            tick();
            n++;
        end
        check(what, 64'(((ch == 0) ? acknowledge_C0 : acknowledge_C1)), 64'(val));
    endtask

    task automatic set_req(input int ch, input logic r, input logic [31:0] d);
        if (ch == 0) begin request_C0 = r; din_C0 = d; end
        else         begin request_C1 = r; din_C1 = d; end
    endtask

    task automatic send_half(input int ch, input logic [31:0] d);
        set_req(ch, 1'b1, d);
        wait_ack(ch, 1'b1, "ack_rise");
        set_req(ch, 1'b0, d);
        wait_ack(ch, 1'b0, "ack_fall");
    endtask

    task automatic send_word(input int ch, input logic [63:0] w);
        send_half(ch, w[63:32]);
        send_half(ch, w[31:0]);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 400) begin
            tick();
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        tick(3);
    endtask

    task automatic do_reset();
        s_axis_aresetn = 1'b0;
        tick(3);
        s_axis_aresetn = 1'b1;
        tick(4);
        log_data.delete();
        log_last.delete();
        done_count = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_axis_aresetn = 1'b0;
        rx_enable      = 1'b1;
        recv_len       = 32'd1;
        m_axis_tready  = 1'b1;
        request_C0 = 1'b0; request_C1 = 1'b0;
        din_C0 = '0; din_C1 = '0;
        tick(4);
        s_axis_aresetn = 1'b1;
        tick(4);

        // 1. Single C0 pair, one-word frame
        log_data.delete(); log_last.delete(); done_count = 0;
        exp_q.push_back(64'hAAAA_0001_0000_BEEF);
        send_half(0, 32'hAAAA_0001);
        send_half(0, 32'h0000_BEEF);
        drain();
        check("t1_beats", 64'(log_data.size()), 64'd1);
        check("t1_data", log_data[0], 64'hAAAA_0001_0000_BEEF);
        check("t1_last", 64'(log_last[0]), 64'd1);
        check("t1_done_pulses", 64'(done_count), 64'd1);
        check("t1_data_cnt", 64'(data_cnt), 64'd1);

        // 2. Both channels concurrently, 8-word frame
        do_reset();
        recv_len = 32'd8;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(w0(k));
            exp_q.push_back(w1(k));
        end
        fork
            begin for (int k = 0; k < 4; k++) send_word(0, w0(k)); end
            begin for (int k = 0; k < 4; k++) send_word(1, w1(k)); end
        join
        drain();
        check("t2_beats", 64'(log_data.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_data.size(); i++)
            check("t2_channel_order", 64'(log_data[i][63:56]), (i % 2 == 1) ? 64'hC1 : 64'hC0);
        for (int i = 0; i < 8 && i < log_last.size(); i++)
            check("t2_last", 64'(log_last[i]), (i == 7) ? 64'd1 : 64'd0);
        check("t2_data_cnt", 64'(data_cnt), 64'd8);
        check("t2_done_pulses", 64'(done_count), 64'd1);

        // 3. Backpressure: three words held, fourth word's lower half refused
        do_reset();
        recv_len      = 32'd8;
        m_axis_tready = 1'b0;
        bp_done       = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back(w0(k));
        fork
            begin
                for (int k = 0; k < 5; k++) send_word(0, w0(k));
                bp_done = 1'b1;
            end
        join_none
        tick(150);
        check("t3_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("t3_tdata", m_axis_tdata, w0(0));
        check("t3_ack_stalled", 64'(acknowledge_C0), 64'd0);
        check("t3_sender_blocked", 64'(bp_done), 64'd0);
        check("t3_data_cnt", 64'(data_cnt), 64'd0);
        m_axis_tready = 1'b1;
        for (int n = 0; n < 600 && !bp_done; n++) tick();
        check("t3_sender_done", 64'(bp_done), 64'd1);
        drain();
        check("t3_beats", 64'(log_data.size()), 64'd5);
        if (log_data.size() == 5) check("t3_fifth", log_data[4], w0(4));

        // 4. recv_len = 0 then 3
        do_reset();
        recv_len = 32'd0;
        exp_q.push_back(w0(10));
        send_word(0, w0(10));
        drain();
        recv_len = 32'd3;
        for (int k = 11; k < 14; k++) exp_q.push_back(w0(k));
        for (int k = 11; k < 14; k++) send_word(0, w0(k));
        drain();
        check("t4_beats", 64'(log_last.size()), 64'd4);
        if (log_last.size() == 4) begin
            check("t4_last0", 64'(log_last[0]), 64'd1);
            check("t4_last1", 64'(log_last[1]), 64'd0);
            check("t4_last2", 64'(log_last[2]), 64'd0);
            check("t4_last3", 64'(log_last[3]), 64'd1);
        end
        check("t4_done_pulses", 64'(done_count), 64'd2);

        // 5. Reset while C1 is acknowledging the lower half
        do_reset();
        recv_len = 32'd1;
        send_half(1, 32'h1111_2222);
        set_req(1, 1'b1, 32'h3333_4444);
        wait_ack(1, 1'b1, "t5_ack_rise");
        s_axis_aresetn = 1'b0;
        #1;
        check("t5_ack_drop", 64'(acknowledge_C1), 64'd0);
        set_req(1, 1'b0, 32'h0);
        tick(3);
        s_axis_aresetn = 1'b1;
        tick(6);
        log_data.delete(); log_last.delete(); done_count = 0;
        exp_q.push_back(64'h1111_2222_3333_4444);
        send_word(1, 64'h1111_2222_3333_4444);
        drain();
        check("t5_beats", 64'(log_data.size()), 64'd1);
        check("t5_data", log_data[0], 64'h1111_2222_3333_4444);
        check("t5_data_cnt", 64'(data_cnt), 64'd1);

        // 6. rx_enable dropped during WAIT_LO
        do_reset();
        recv_len = 32'd1;
        exp_q.push_back(64'h5555_6666_7777_8888);
        set_req(0, 1'b1, 32'h5555_6666);
        wait_ack(0, 1'b1, "t6_ack_rise");
        rx_enable = 1'b0;
        set_req(0, 1'b0, 32'h5555_6666);
        wait_ack(0, 1'b0, "t6_ack_fall");
        set_req(0, 1'b1, 32'h7777_8888);
        tick(20);
        check("t6_no_ack_disabled", 64'(acknowledge_C0), 64'd0);
        rx_enable = 1'b1;
        wait_ack(0, 1'b1, "t6_ack_enabled");
        set_req(0, 1'b0, 32'h7777_8888);
        wait_ack(0, 1'b0, "t6_ack_fall2");
        drain();
        check("t6_beats", 64'(log_data.size()), 64'd1);
        check("t6_data", log_data[0], 64'h5555_6666_7777_8888);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
